// File: rtl/tt6581_pkg.sv
// Shared constants for the multichannel PDM output block: modulator order
// selectors and the dither LFSR seed, tap mask and step function.
package tt6581_pkg;

   localparam int ORDER_1 = 1;
   localparam int ORDER_2 = 2;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: taps at bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      lfsr_next = {^(cur & LFSR_TAPS), cur[15:1]};
   endfunction

endpackage

// File: rtl/pdm_dsm_core.sv
// One delta-sigma channel: first- or second-order integrator chain with a
// 1-bit quantiser, updated once per modulator step.
module pdm_dsm_core
   import tt6581_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int ORDER  = ORDER_1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   step,
   input  logic signed [DATA_W:0] x,
   output logic                   pdm
);

   localparam int IW = (ORDER == ORDER_2) ? DATA_W + 4 : DATA_W + 2;
   localparam int SW = IW + 2;
   localparam logic signed [SW-1:0] FB_POS = {{(SW-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [SW-1:0] FB_NEG = -FB_POS;
   localparam logic signed [SW-1:0] SMAX   = {3'b000, {(IW-1){1'b1}}};
   localparam logic signed [SW-1:0] SMIN   = {3'b111, {(IW-1){1'b0}}};

   logic signed [SW-1:0] fb;
   logic signed [SW-1:0] sum1;
   logic signed [SW-1:0] sum2;
   logic signed [IW-1:0] i1;
   logic signed [IW-1:0] i2;
   logic signed [IW-1:0] i1_next;
   logic signed [IW-1:0] i2_next;
   logic                 pdm_next;

   function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
      if (v > SMAX) begin
         sat = SMAX[IW-1:0];
      end else if (v < SMIN) begin
         sat = SMIN[IW-1:0];
      end else begin
         sat = v[IW-1:0];
      end
   endfunction

   // Integrator update; a first-order loop never reaches the clamp, so it is shared.
   always_comb begin
      fb       = pdm ? FB_POS : FB_NEG;
      sum1     = SW'(i1) + SW'(x) - fb;
      i1_next  = sat(sum1);
      sum2     = SW'(i2) + SW'(i1_next) - fb;
      i2_next  = sat(sum2);
      pdm_next = (ORDER == ORDER_2) ? ~i2_next[IW-1] : ~i1_next[IW-1];
   end

   // Integrator and output state, advanced only on modulator steps.
   always_ff @(posedge clk) begin
      if (rst) begin
         i1  <= {IW{1'b0}};
         i2  <= {IW{1'b0}};
         pdm <= 1'b0;
      end else if (step) begin
         i1  <= i1_next;
         i2  <= i2_next;
         pdm <= pdm_next;
      end
   end

endmodule

// File: rtl/pdm_out_mc.sv
// Multichannel PDM output: step divider, frame counter, one-deep sample
// handshake and per-channel modulators. Optional LSB dither: PDM_DITHER_EN.
module pdm_out_mc
   import tt6581_pkg::*;
#(
   parameter int NUM_CH  = 1,
   parameter int DATA_W  = 12,
   parameter int ORDER   = ORDER_1,
   parameter int CLK_DIV = 4,
   parameter int OSR     = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     s_valid_i,
   output logic                     s_ready_o,
   input  logic [NUM_CH*DATA_W-1:0] s_data_i,
   input  logic                     enable_i,
   output logic [NUM_CH-1:0]        pdm_o,
   output logic                     frame_o,
   output logic                     underrun_o
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W = $clog2(OSR);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

   logic [DIV_W-1:0]         div_cnt;
   logic [CNT_W-1:0]         step_cnt;
   logic                     step;
   logic                     boundary;
   logic                     accept;
   logic                     pend_full;
   logic [NUM_CH*DATA_W-1:0] pending;
   logic [NUM_CH*DATA_W-1:0] active;
   logic signed [DATA_W:0]   dither;

   assign step     = enable_i && (div_cnt == DIV_LAST);
   assign boundary = step && (step_cnt == CNT_LAST);
   assign accept   = s_valid_i && s_ready_o;

   // Clock divider and step counter; both hold while disabled.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_cnt  <= {DIV_W{1'b0}};
         step_cnt <= {CNT_W{1'b0}};
      end else if (enable_i) begin
         div_cnt <= (div_cnt == DIV_LAST) ? {DIV_W{1'b0}} : div_cnt + 1'b1;
         if (step) begin
            step_cnt <= (step_cnt == CNT_LAST) ? {CNT_W{1'b0}} : step_cnt + 1'b1;
         end
      end
   end

   // Handshake and frame bookkeeping; ready only rises once pending has drained,
   // so a boundary never sees an accept while pending is still full.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pending    <= {(NUM_CH*DATA_W){1'b0}};
         active     <= {(NUM_CH*DATA_W){1'b0}};
         pend_full  <= 1'b0;
         s_ready_o  <= 1'b0;
         frame_o    <= 1'b0;
         underrun_o <= 1'b0;
      end else begin
         frame_o    <= boundary;
         underrun_o <= boundary && !pend_full && !accept;
         if (boundary && pend_full) begin
            active    <= pending;
            pend_full <= 1'b0;
            s_ready_o <= 1'b1;
         end else if (accept) begin
            pending   <= s_data_i;
            pend_full <= 1'b1;
            s_ready_o <= 1'b0;
         end else begin
            s_ready_o <= !pend_full;
         end
      end
   end

`ifdef PDM_DITHER_EN
   logic [15:0] lfsr;

   // Dither source, one shift per modulator step.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr <= LFSR_SEED;
      end else if (step) begin
         lfsr <= lfsr_next(lfsr);
      end
   end

   assign dither = {{DATA_W{1'b0}}, lfsr[0]};
`else
   assign dither = {(DATA_W+1){1'b0}};
`endif

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic signed [DATA_W:0] x;

      // One guard bit so that +full-scale plus dither cannot wrap.
      assign x = {active[(ch+1)*DATA_W-1], active[ch*DATA_W +: DATA_W]} + dither;

      pdm_dsm_core #(
         .DATA_W(DATA_W),
         .ORDER (ORDER)
      ) u_core (
         .clk (clk_i),
         .rst (rst_i),
         .step(step),
         .x   (x),
         .pdm (pdm_o[ch])
      );
   end

endmodule
